// File: rtl/bus_arbiter5.sv
// Round-robin arbiter for the five sources of the shared 8-bit bus.
// Drives a registered one-hot grant and 5:1 mux select with a bounded hold time.
module bus_arbiter5 #(
  parameter int unsigned MAX_HOLD = 4,
  parameter logic [2:0]  IDLE_SEL = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  output logic [4:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       gnt_change
);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       chg_q, chg_d;

  logic [4:0] others;
  logic [4:0] cand;
  logic [2:0] new_idx;
  logic       take_new;
  logic       hold;

  // First set bit of c scanning p+1, p+2, ... modulo 5; the reverse loop
  // lets the earliest position in scan order win.
  function automatic logic [2:0] pick(input logic [4:0] c, input logic [2:0] p);
    logic [2:0] r;
    logic [3:0] idx;
    r = p;
    for (int k = 5; k >= 1; k--) begin
      idx = 4'(p) + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (c[idx[2:0]]) r = idx[2:0];
    end
    return r;
  endfunction

  // In GRANT the pointer always holds the current owner's index.
  assign others  = req & ~gnt_q;
  assign new_idx = pick(cand, ptr_q);

  always_comb begin
    cand     = req;
    take_new = 1'b0;
    hold     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) take_new = 1'b1;
      end
      ST_GRANT: begin
        if (!req[ptr_q]) begin
          cand = others;
          if (|others) take_new = 1'b1;
        end else if (cnt_q == HOLD && |others) begin
          cand     = others;
          take_new = 1'b1;
        end else begin
          hold = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = ST_IDLE;
    ptr_d   = ptr_q;
    cnt_d   = 4'd0;
    sel_d   = IDLE_SEL;
    busy_d  = 1'b0;
    chg_d   = 1'b0;
    if (take_new) begin
      state_d = ST_GRANT;
      ptr_d   = new_idx;
      cnt_d   = 4'd1;
      sel_d   = new_idx;
      busy_d  = 1'b1;
      chg_d   = 1'b1;
    end else if (hold) begin
      state_d = ST_GRANT;
      cnt_d   = (cnt_q == HOLD) ? cnt_q : cnt_q + 4'd1;
      sel_d   = ptr_q;
      busy_d  = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_onehot
    assign gnt_d[gi] = busy_d && (sel_d == 3'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd4;
      cnt_q   <= 4'd0;
      gnt_q   <= 5'd0;
      sel_q   <= IDLE_SEL;
      busy_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      chg_q   <= chg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert (!busy_q || (sel_q <= 3'd4 && gnt_q == (5'd1 << sel_q)));
      assert (busy_q || sel_q == IDLE_SEL);
      assert (sel_q <= 3'd4 || sel_q == IDLE_SEL);
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign gnt_change = chg_q;

endmodule

// File: tb/tb_bus_arbiter5.sv
// Bench for bus_arbiter5: directed scenarios plus random traffic, each cycle
// compared against an integer-level model of the round-robin/hold rules.
module tb_bus_arbiter5;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = 5'd0;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       gnt_change;

  int errors = 0;
  int checks = 0;

  // Model state: owner -1 means idle.
  int m_owner = -1;
  int m_ptr   = 4;
  int m_cnt   = 0;
  int m_chg   = 0;

  logic [4:0] e_gnt;
  logic [2:0] e_sel;
  logic       e_busy;
  logic       e_chg;

  bus_arbiter5 #(.MAX_HOLD(MAXH), .IDLE_SEL(3'd7)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .sel(sel), .busy(busy), .gnt_change(gnt_change)
  );

  always #5 clk = ~clk;

  function automatic int m_pick(input logic [4:0] c, input int p);
    for (int k = 1; k <= 5; k++) begin
      if (c[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [4:0] r, input logic rs);
    logic [4:0] oth;
    if (rs) begin
      m_owner = -1; m_ptr = 4; m_cnt = 0; m_chg = 0;
    end else if (m_owner < 0) begin
      if (r != 5'd0) begin
        m_owner = m_pick(r, m_ptr); m_ptr = m_owner; m_cnt = 1; m_chg = 1;
      end else begin
        m_chg = 0;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner] || (m_cnt == MAXH && oth != 5'd0)) begin
        if (oth != 5'd0) begin
          m_owner = m_pick(oth, m_ptr); m_ptr = m_owner; m_cnt = 1; m_chg = 1;
        end else begin
          m_owner = -1; m_cnt = 0; m_chg = 0;
        end
      end else begin
        m_cnt = (m_cnt < MAXH) ? m_cnt + 1 : MAXH;
        m_chg = 0;
      end
    end
    e_gnt  = (m_owner < 0) ? 5'd0 : 5'(1 << m_owner);
    e_sel  = (m_owner < 0) ? 3'd7 : 3'(m_owner);
    e_busy = (m_owner >= 0);
    e_chg  = (m_chg != 0);
  endtask

  task automatic tick(input logic [4:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      tick(5'b11111, 1'b1);
      checks++;
      if ({gnt, sel, busy, gnt_change} !== {5'd0, 3'd7, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b sel=%0d busy=%b chg=%b, want gnt=00000 sel=7 busy=0 chg=0",
                 gnt, sel, busy, gnt_change);
      end
    end
    tick(5'b11111, 1'b0);
    checks++;
    if ({gnt, sel, gnt_change} !== {5'b00001, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_first_grant: gnt=%b sel=%0d chg=%b, want gnt=00001 sel=0 chg=1",
               gnt, sel, gnt_change);
    end
  endtask

  task automatic test_single;
    tick(5'b00000, 1'b0);
    tick(5'b00000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(5'b00100, 1'b0);
      checks++;
      if ({gnt, sel, busy, gnt_change} !== {5'b00100, 3'd2, 1'b1, (i == 0)}) begin
        errors++;
        $display("FAIL single_hold[%0d]: gnt=%b sel=%0d busy=%b chg=%b, want gnt=00100 sel=2 busy=1 chg=%0d",
                 i, gnt, sel, busy, gnt_change, (i == 0));
      end
    end
    tick(5'b00000, 1'b0);
    checks++;
    if ({gnt, sel, busy} !== {5'd0, 3'd7, 1'b0}) begin
      errors++;
      $display("FAIL single_release: gnt=%b sel=%0d busy=%b, want gnt=00000 sel=7 busy=0",
               gnt, sel, busy);
    end
  endtask

  task automatic test_preempt;
    logic [2:0] want;
    for (int i = 0; i < 12; i++) begin
      tick(5'b00011, 1'b0);
      want = ((i / MAXH) % 2 == 0) ? 3'd0 : 3'd1;
      checks++;
      if (sel !== want || gnt_change !== ((i % MAXH) == 0) || gnt !== e_gnt) begin
        errors++;
        $display("FAIL preempt[%0d]: sel=%0d chg=%b gnt=%b, want sel=%0d chg=%0d gnt=%b",
                 i, sel, gnt_change, gnt, want, ((i % MAXH) == 0), e_gnt);
      end
    end
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_wrap;
    tick(5'b01000, 1'b0);
    tick(5'b01000, 1'b0);
    checks++;
    if (sel !== 3'd3) begin
      errors++;
      $display("FAIL wrap_own3: sel=%0d, want sel=3", sel);
    end
    tick(5'b10001, 1'b0);
    checks++;
    if ({sel, busy, gnt_change} !== {3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wrap_handover4: sel=%0d busy=%b chg=%b, want sel=4 busy=1 chg=1",
               sel, busy, gnt_change);
    end
    tick(5'b00001, 1'b0);
    checks++;
    if ({sel, gnt, gnt_change} !== {3'd0, 5'b00001, 1'b1}) begin
      errors++;
      $display("FAIL wrap_handover0: sel=%0d gnt=%b chg=%b, want sel=0 gnt=00001 chg=1",
               sel, gnt, gnt_change);
    end
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_fairness;
    int cyc_cnt [5];
    int first;
    logic [2:0] want;
    foreach (cyc_cnt[s]) cyc_cnt[s] = 0;
    first = (m_ptr + 1) % 5;
    for (int i = 0; i < 40; i++) begin
      tick(5'b11111, 1'b0);
      want = 3'((first + i / MAXH) % 5);
      if (sel <= 3'd4) cyc_cnt[sel]++;
      checks++;
      if (sel !== want || {gnt, busy, gnt_change} !== {e_gnt, e_busy, e_chg}) begin
        errors++;
        $display("FAIL fair[%0d]: sel=%0d gnt=%b chg=%b, want sel=%0d gnt=%b chg=%b",
                 i, sel, gnt, gnt_change, want, e_gnt, e_chg);
      end
    end
    for (int s = 0; s < 5; s++) begin
      checks++;
      if (cyc_cnt[s] != 2 * MAXH) begin
        errors++;
        $display("FAIL fair_share[%0d]: cycles=%0d, want %0d", s, cyc_cnt[s], 2 * MAXH);
      end
    end
    tick(5'b00000, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [2:0] want;
    tick(5'b01000, 1'b0);
    tick(5'b01000, 1'b0);
    tick(5'b01000, 1'b1);
    checks++;
    if ({gnt, sel, busy, gnt_change} !== {5'd0, 3'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_drop: gnt=%b sel=%0d busy=%b chg=%b, want gnt=00000 sel=7 busy=0 chg=0",
               gnt, sel, busy, gnt_change);
    end
    tick(5'b01000, 1'b0);
    checks++;
    if ({sel, gnt_change} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL midreset_regrant: sel=%0d chg=%b, want sel=3 chg=1", sel, gnt_change);
    end
    for (int i = 0; i < 4; i++) begin
      tick(5'b01001, 1'b0);
      want = (i < 3) ? 3'd3 : 3'd0;
      checks++;
      if (sel !== want) begin
        errors++;
        $display("FAIL midreset_count[%0d]: sel=%0d, want sel=%0d", i, sel, want);
      end
    end
  endtask

  task automatic test_random;
    logic [4:0] r;
    logic [4:0] flip;
    logic       rs;
    r = 5'b00000;
    for (int i = 0; i < 400; i++) begin
      flip = 5'd0;
      for (int b = 0; b < 5; b++) flip[b] = ($urandom_range(0, 3) == 0);
      r  = r ^ flip;
      rs = ($urandom_range(0, 49) == 0);
      tick(r, rs);
      checks++;
      if ({gnt, sel, busy, gnt_change} !== {e_gnt, e_sel, e_busy, e_chg}) begin
        errors++;
        $display("FAIL random[%0d]: req=%b rst=%b gnt=%b sel=%0d busy=%b chg=%b, want gnt=%b sel=%0d busy=%b chg=%b",
                 i, r, rs, gnt, sel, busy, gnt_change, e_gnt, e_sel, e_busy, e_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_wrap();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
